// File: rtl/sd_cmd_receiver.sv
// -----------------------------------------------------------------------------
// sd_cmd_receiver
//
// Receives SD card responses on the CMD line. The line is sampled once per
// SD clock, at the one-iclk strobe `isample`. The receiver waits for a start
// bit, shifts in a 48-bit short response (or a 136-bit R2 response when built
// with SD_R2_RESP_EN), checks framing and CRC7, and then presents the decoded
// fields together with a one-cycle done pulse.
//
// Build option: define SD_R2_RESP_EN to support 136-bit R2 responses. The
// default build handles 48-bit frames only and ties olong to zero.
//
// Ports
//   iclk        system clock; all logic on the rising edge
//   irst        synchronous active-high reset
//   isample     one-iclk strobe marking the CMD sampling point
//   istart      arm the receiver (accepted only when idle)
//   ilong       expect a 136-bit R2 frame (used only with SD_R2_RESP_EN)
//   icmd        raw, asynchronous CMD line
//   obusy       high from arming until the done cycle
//   odone       one-cycle completion pulse
//   oindex      response bits [45:40], the command index
//   oarg        response bits [39:8]
//   olong       R2 bits [127:8]
//   ocrc_err    CRC7 mismatch, valid with odone
//   oframe_err  transmission bit was 1 or end bit was 0, valid with odone
//   otimeout    no start bit within TIMEOUT strobes, valid with odone
// -----------------------------------------------------------------------------
module sd_cmd_receiver #(
  parameter int TIMEOUT = 64
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         isample,
  input  logic         istart,
  input  logic         ilong,
  input  logic         icmd,
  output logic         obusy,
  output logic         odone,
  output logic [5:0]   oindex,
  output logic [31:0]  oarg,
  output logic [119:0] olong,
  output logic         ocrc_err,
  output logic         oframe_err,
  output logic         otimeout
);

`ifdef SD_R2_RESP_EN
  localparam int SR_W = 136;
`else
  localparam int SR_W = 48;
`endif
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RECEIVE    = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic              cmd_meta;
  logic              cmd_sync;
  logic [SR_W-1:0]   shreg;
  logic [SR_W-1:0]   shreg_next;
  logic [6:0]        crc;
  logic [7:0]        bit_cnt;
  logic [7:0]        bit_cnt_next;
  logic [7:0]        frame_len;
  logic [7:0]        crc_top;
  logic [7:0]        bit_idx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              long_mode;
  logic              last_bit;
  logic              in_crc;
  logic              tmo_hit;
  logic              trans_bit;
  logic              crc_bad;
  logic              frame_bad;

  logic              arm;
  logic              start_seen;
  logic              tmo_tick;
  logic              shift_en;
  logic              finish_frame;
  logic              finish_tmo;

  logic              unused_bits;

  // One CRC7 step (x^7 + x^3 + 1), MSB-first serial update.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc_in, input logic din);
    logic fb;
    fb = din ^ crc_in[6];
    crc7_step = {crc_in[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Two-flop synchronizer for the asynchronous CMD line; idles high.
  always_ff @(posedge iclk) begin
    if (irst) begin
      cmd_meta <= 1'b1;
      cmd_sync <= 1'b1;
    end else begin
      cmd_meta <= icmd;
      cmd_sync <= cmd_meta;
    end
  end

  // Frame geometry and the bit currently being captured. bit_idx is the
  // frame bit number (N-1 = start bit ... 0 = end bit) of the incoming sample.
  assign frame_len    = long_mode ? 8'd136 : 8'd48;
  assign crc_top      = long_mode ? 8'd127 : 8'd47;
  assign bit_cnt_next = bit_cnt + 8'd1;
  assign bit_idx      = frame_len - bit_cnt_next;
  assign last_bit     = (bit_cnt_next == frame_len);
  assign in_crc       = (bit_idx >= 8'd8) && (bit_idx <= crc_top);
  assign tmo_hit      = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign shreg_next   = {shreg[SR_W-2:0], cmd_sync};

  // The CRC register already covers everything down to bit 8 when the end
  // bit arrives, so the checks use the shift register including this sample.
`ifdef SD_R2_RESP_EN
  assign trans_bit = long_mode ? shreg_next[134] : shreg_next[46];
`else
  assign trans_bit = shreg_next[46];
`endif
  assign crc_bad   = (crc != shreg_next[7:1]);
  assign frame_bad = trans_bit | ~shreg_next[0];

  // Start bit, the dropped shift-out bit and unused header bits are not fields.
  assign unused_bits = ^{shreg[SR_W-1], shreg_next, ilong};

  // FSM state register.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (istart) begin
          state_next = ST_WAIT_START;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_START: begin
        if (isample && !cmd_sync) begin
          state_next = ST_RECEIVE;
        end else if (isample && tmo_hit) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_WAIT_START;
        end
      end
      ST_RECEIVE: begin
        if (isample && last_bit) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RECEIVE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: per-state control strobes for datapath and outputs.
  always_comb begin
    arm          = 1'b0;
    start_seen   = 1'b0;
    tmo_tick     = 1'b0;
    shift_en     = 1'b0;
    finish_frame = 1'b0;
    finish_tmo   = 1'b0;
    case (state)
      ST_IDLE: begin
        arm = istart;
      end
      ST_WAIT_START: begin
        start_seen = isample & ~cmd_sync;
        tmo_tick   = isample & cmd_sync & ~tmo_hit;
        finish_tmo = isample & cmd_sync & tmo_hit;
      end
      ST_RECEIVE: begin
        shift_en     = isample;
        finish_frame = isample & last_bit;
      end
      ST_DONE: begin
        arm = 1'b0;
      end
      default: begin
        arm = 1'b0;
      end
    endcase
  end

  // Receive datapath: shift register, CRC accumulator and counters.
  always_ff @(posedge iclk) begin
    if (irst) begin
      shreg     <= '0;
      crc       <= 7'd0;
      bit_cnt   <= 8'd0;
      tmo_cnt   <= '0;
      long_mode <= 1'b0;
    end else if (arm) begin
      shreg     <= '0;
      crc       <= 7'd0;
      bit_cnt   <= 8'd0;
      tmo_cnt   <= '0;
`ifdef SD_R2_RESP_EN
      long_mode <= ilong;
`else
      long_mode <= 1'b0;
`endif
    end else if (start_seen) begin
      // Start bit is frame bit 1; feeding its 0 into a zero CRC keeps it zero.
      shreg   <= shreg_next;
      crc     <= crc7_step(7'd0, 1'b0);
      bit_cnt <= 8'd1;
    end else if (tmo_tick) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else if (shift_en) begin
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      if (in_crc) begin
        crc <= crc7_step(crc, cmd_sync);
      end
    end
  end

  // Output registers: done pulse, busy flag, status flags and short fields.
  always_ff @(posedge iclk) begin
    if (irst) begin
      obusy      <= 1'b0;
      odone      <= 1'b0;
      oindex     <= 6'd0;
      oarg       <= 32'd0;
      ocrc_err   <= 1'b0;
      oframe_err <= 1'b0;
      otimeout   <= 1'b0;
    end else begin
      odone <= finish_frame | finish_tmo;
      if (arm) begin
        obusy <= 1'b1;
      end else if (finish_frame || finish_tmo) begin
        obusy <= 1'b0;
      end
      if (arm) begin
        ocrc_err   <= 1'b0;
        oframe_err <= 1'b0;
        otimeout   <= 1'b0;
      end else if (finish_tmo) begin
        otimeout <= 1'b1;
      end else if (finish_frame) begin
        ocrc_err   <= crc_bad;
        oframe_err <= frame_bad;
        if (!long_mode) begin
          oindex <= shreg_next[45:40];
          oarg   <= shreg_next[39:8];
        end
      end
    end
  end

`ifdef SD_R2_RESP_EN
  // R2 payload register, loaded only when a 136-bit frame completes.
  always_ff @(posedge iclk) begin
    if (irst) begin
      olong <= 120'd0;
    end else if (finish_frame && long_mode) begin
      olong <= shreg_next[127:8];
    end
  end
`else
  assign olong = 120'd0;
`endif

endmodule

// File: tb/tb_sd_cmd_receiver.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_receiver
//
// Self-checking bench for sd_cmd_receiver. Frames are streamed bit by bit with
// one isample strobe every four iclk cycles. Expected fields and flags come
// from a frame-level reference model: CRC7 by polynomial long division, fields
// sliced straight from the frame vector, timeout decided by the idle count.
// -----------------------------------------------------------------------------
module tb_sd_cmd_receiver;
  localparam int TIMEOUT = 64;

  logic         iclk = 1'b0;
  logic         irst;
  logic         isample;
  logic         istart;
  logic         ilong;
  logic         icmd;
  logic         obusy;
  logic         odone;
  logic [5:0]   oindex;
  logic [31:0]  oarg;
  logic [119:0] olong;
  logic         ocrc_err;
  logic         oframe_err;
  logic         otimeout;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_done  = 0;

  // Reference-model copies of the held output fields.
  logic [5:0]   m_index;
  logic [31:0]  m_arg;
  logic [119:0] m_long;

  sd_cmd_receiver #(.TIMEOUT(TIMEOUT)) dut (
    .iclk       (iclk),
    .irst       (irst),
    .isample    (isample),
    .istart     (istart),
    .ilong      (ilong),
    .icmd       (icmd),
    .obusy      (obusy),
    .odone      (odone),
    .oindex     (oindex),
    .oarg       (oarg),
    .olong      (olong),
    .ocrc_err   (ocrc_err),
    .oframe_err (oframe_err),
    .otimeout   (otimeout)
  );

  always #5 iclk = ~iclk;

  // Count every done pulse seen, to catch missing or spurious completions.
  always @(negedge iclk) begin
    if (odone === 1'b1) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iclk);
    #1;
  endtask

  // Present one CMD bit and strobe it well after the synchronizer settles.
  task automatic strobe(input logic b);
    icmd = b;
    tick;
    tick;
    tick;
    isample = 1'b1;
    tick;
    isample = 1'b0;
  endtask

  // CRC7 of frame bits hi..lo: remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc_of(input logic [135:0] f, input int hi, input int lo);
    logic [142:0] m;
    logic [142:0] g;
    m = '0;
    g = 143'h89;
    for (int i = hi; i >= lo; i--) m = {m[141:0], f[i]};
    m = {m[135:0], 7'd0};
    for (int p = 142; p >= 7; p--) begin
      if (m[p]) m = m ^ (g << (p - 7));
    end
    return m[6:0];
  endfunction

  // Well-formed short frame with an optional corruption:
  // 1 = CRC flipped, 2 = transmission bit set, 3 = end bit cleared.
  function automatic logic [135:0] make_short(input logic [5:0] idx, input logic [31:0] arg,
                                              input int corrupt);
    logic [135:0] f;
    logic [6:0]   c;
    f = '0;
    f[45:40] = idx;
    f[39:8]  = arg;
    c = crc_of(f, 47, 8);
    f[7:1] = c;
    f[0]   = 1'b1;
    case (corrupt)
      1: f[7:1] = c ^ 7'h25;
      2: f[46] = 1'b1;
      3: f[0] = 1'b0;
      default: f[0] = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [135:0] make_long(input logic [119:0] payload);
    logic [135:0] f;
    f = '0;
    f[133:128] = 6'h3F;
    f[127:8]   = payload;
    f[7:1]     = crc_of(f, 127, 8);
    f[0]       = 1'b1;
    return f;
  endfunction

  // Arm, stream idle strobes and the frame, and check the completion cycle.
  task automatic run_frame(input string tag, input logic [135:0] f, input bit lng, input int idle,
                           input bit mid_start, input bit start_at_done);
    int   d0;
    int   len;
    bit   tmo;
    logic exp_crc;
    logic exp_frm;
    len = lng ? 136 : 48;
    tmo = (idle >= TIMEOUT);
    ilong  = lng;
    istart = 1'b1;
    tick;
    istart = 1'b0;
    ilong  = 1'b0;
    @(negedge iclk);
    chk({tag, "/busy_rise"}, 128'(obusy), 128'(1'b1));
    chk({tag, "/flags_clear"}, 128'({otimeout, oframe_err, ocrc_err}), 128'(3'b000));
    d0 = n_done;
    for (int i = 0; i < (tmo ? TIMEOUT : idle); i++) strobe(1'b1);
    if (!tmo) begin
      for (int i = len - 1; i >= 0; i--) begin
        if (mid_start && i == len - 10) begin
          istart = 1'b1;
          tick;
          istart = 1'b0;
        end
        strobe(f[i]);
      end
    end
    if (tmo) begin
      exp_crc = 1'b0;
      exp_frm = 1'b0;
    end else begin
      exp_crc = lng ? (crc_of(f, 127, 8) != f[7:1]) : (crc_of(f, 47, 8) != f[7:1]);
      exp_frm = f[len-2] | ~f[0];
      if (lng) begin
        m_long = f[127:8];
      end else begin
        m_index = f[45:40];
        m_arg   = f[39:8];
      end
    end
    @(negedge iclk);
    chk({tag, "/done"}, 128'(odone), 128'(1'b1));
    chk({tag, "/busy_fall"}, 128'(obusy), 128'(1'b0));
    chk({tag, "/flags"}, 128'({otimeout, oframe_err, ocrc_err}), 128'({tmo, exp_frm, exp_crc}));
    chk({tag, "/index"}, 128'(oindex), 128'(m_index));
    chk({tag, "/arg"}, 128'(oarg), 128'(m_arg));
    chk({tag, "/long"}, 128'(olong), 128'(m_long));
    if (start_at_done) istart = 1'b1;
    tick;
    istart = 1'b0;
    @(negedge iclk);
    chk({tag, "/done_width"}, 128'(odone), 128'(1'b0));
    chk({tag, "/idle_after"}, 128'(obusy), 128'(1'b0));
    chk({tag, "/done_count"}, 128'(n_done - d0), 128'(1));
    tick;
  endtask

  initial begin
    logic [135:0] f;
    int           d0;
    int           idle;

    irst    = 1'b1;
    isample = 1'b0;
    istart  = 1'b0;
    ilong   = 1'b0;
    icmd    = 1'b1;
    m_index = 6'd0;
    m_arg   = 32'd0;
    m_long  = 120'd0;
    repeat (3) tick;
    irst = 1'b0;
    @(negedge iclk);
    chk("reset/outputs", 128'({obusy, odone, otimeout, oframe_err, ocrc_err}), 128'(5'd0));
    chk("reset/fields", {2'b00, oindex, oarg, olong[87:0]}, 128'd0);
    chk("reset/long", 128'(olong), 128'd0);

    // Directed frames from the test plan.
    f = '0;
    f[47:0] = 48'h08_0000_01AA_13;
    run_frame("good", f, 1'b0, 20, 1'b0, 1'b0);
    f[7:0] = 8'h15;
    run_frame("bad_crc", f, 1'b0, 5, 1'b0, 1'b0);
    run_frame("timeout", f, 1'b0, TIMEOUT, 1'b0, 1'b0);
    f[7:0] = 8'h13;
    run_frame("idle_63", f, 1'b0, TIMEOUT - 1, 1'b0, 1'b0);
    f = make_short(6'h11, 32'hDEAD_BEEF, 3);
    run_frame("end_bit", f, 1'b0, 2, 1'b0, 1'b0);
    f = make_short(6'h37, 32'h1234_5678, 2);
    run_frame("trans_bit", f, 1'b0, 0, 1'b1, 1'b1);

    // Reset in the middle of a frame: no completion, outputs back to zero.
    f = make_short(6'h29, 32'hCAFE_0001, 0);
    istart = 1'b1;
    tick;
    istart = 1'b0;
    d0 = n_done;
    repeat (3) strobe(1'b1);
    for (int i = 47; i >= 28; i--) strobe(f[i]);
    irst = 1'b1;
    tick;
    irst = 1'b0;
    m_index = 6'd0;
    m_arg   = 32'd0;
    m_long  = 120'd0;
    @(negedge iclk);
    chk("rst_mid/outputs", 128'({obusy, odone, otimeout, oframe_err, ocrc_err}), 128'(5'd0));
    chk("rst_mid/fields", 128'({oindex, oarg}), 128'd0);
    for (int i = 27; i >= 0; i--) strobe(f[i]);
    tick;
    chk("rst_mid/no_done", 128'(n_done - d0), 128'(0));
    chk("rst_mid/idle", 128'(obusy), 128'(1'b0));
    run_frame("after_rst", f, 1'b0, 7, 1'b0, 1'b0);

`ifdef SD_R2_RESP_EN
    f = make_long({64'h1D41_4453_4430_3030, 56'd0});
    run_frame("r2_cid", f, 1'b1, 10, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      f = make_long({$urandom(), $urandom(), $urandom(), 24'($urandom())});
      if (k == 1) f[5] = ~f[5];
      run_frame("r2_rand", f, 1'b1, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0);
    end
`endif

    // Randomized short frames, corruptions, idle gaps and ignored starts.
    for (int k = 0; k < 10; k++) begin
      f = make_short(6'($urandom()), $urandom(), int'($urandom_range(0, 4)));
      idle = (k == 4) ? TIMEOUT + int'($urandom_range(0, 5)) : int'($urandom_range(0, 30));
      run_frame("rand", f, 1'b0, idle, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sd_cmd_receiver.md
# sd_cmd_receiver

Receives SD card responses on the CMD line, sampled at SD-clock rate via a one-cycle strobe from the SD clock divider path. It detects the start bit, shifts in a 48-bit short response (optionally a 136-bit R2 response), checks framing and CRC7, and presents the decoded fields with a done pulse. It sits between the card CMD pad and the SD command controller, opposite the command transmitter.

## Interface
- TIMEOUT, 64: SD-clock sample strobes allowed between arming and the start bit (NCR).
- iclk  in  1  system clock; all logic on posedge.
- irst  in  1  reset, synchronous, active-high.
- isample  in  1  one-iclk strobe marking the CMD sampling point.
- istart  in  1  arm the receiver; accepted only in IDLE.
- ilong  in  1  1 = expect 136-bit R2; ignored without SD_R2_RESP_EN.
- icmd  in  1  raw CMD line input, asynchronous.
- obusy  out  1  high from arming until the done cycle.
- odone  out  1  one-cycle completion pulse.
- oindex  out  6  response bits [45:40], the command index field.
- oarg  out  32  response bits [39:8].
- olong  out  120  R2 bits [127:8]; 0 without the macro.
- ocrc_err  out  1  CRC7 mismatch; valid with odone.
- oframe_err  out  1  transmission bit 1 or end bit 0; valid with odone.
- otimeout  out  1  no start bit within TIMEOUT strobes; valid with odone.

## Operation
- icmd passes through a 2-flop synchronizer. All sampling uses the synchronized value. Upstream places isample at least 2 iclk after the SD clock edge.
- **IDLE**: obusy=0. istart=1 clears the shift register, CRC, error flags and counters, then goes to WAIT_START.
- **WAIT_START**: on each isample:
  - sampled 0 -> RECEIVE. The start bit counts as bit 1, and CRC is seeded with 0 then fed 0.
  - otherwise the timeout counter increments. Reaching TIMEOUT -> DONE with otimeout=1.
- **RECEIVE**: on each isample, shift the sampled bit in MSB-first and increment the bit counter. Total length N = 48, or 136 for R2.
  - Short response: CRC7 (x^7+x^3+1, init 0) covers bits 47..8 and is compared with bits 7..1.
  - R2: CRC covers bits 127..8 only and is compared with bits 7..1. Bits 135..128 are excluded.
  - Transmission bit (second bit) must be 0. Bit 0 (end bit) must be 1.
  - After bit N -> DONE.
- **DONE**: lasts one cycle.
  - Assert odone and latch the outputs: oindex/oarg for short, olong for R2.
  - Then go to IDLE.
- Outputs hold until the next accepted istart. Error flags clear at the next istart.
- Reset values: obusy=0, odone=0, oindex=0, oarg=0, olong=0, all error flags 0, state IDLE, synchronizer flops 1.
- isample is ignored in IDLE and DONE.

## Timing
- odone rises 1 iclk after the isample that captured bit 0. Fields and flags are valid in that same cycle.
- obusy rises the cycle after istart and falls in the cycle odone is high.
- istart coincident with odone: ignored. istart is accepted from the next IDLE cycle on.
- istart while obusy=1: ignored.
- irst mid-frame: aborts to IDLE next edge with all outputs at reset values. No odone is issued.
- Timeout: odone and otimeout=1 come 1 iclk after the TIMEOUT-th strobe. oindex/oarg/olong are unchanged.
- isample held high for multiple cycles: each high cycle counts as a sample. Upstream guarantees single-cycle pulses.

## Configuration
- SD_R2_RESP_EN defined:
  - ilong=1 at istart selects the 136-bit frame.
  - olong is registered.
  - The shift register is 136 bits.
- Not defined:
  - ilong is ignored; every frame is 48 bits.
  - olong is tied to 0.
  - The shift register is 48 bits.

## Test plan
- Short frame 0x08_0000_01AA_13 streamed MSB-first with start 20 idle strobes after istart -> odone, oindex=0x08, oarg=0x000001AA, all errors 0.
- Same frame with the CRC byte 0x13 replaced by 0x15 -> odone, ocrc_err=1, oframe_err=0, fields still latched.
- CMD held at 1 for 64 strobes after istart -> odone on the 64th strobe, otimeout=1, obusy falls.
- End bit forced to 0 in a valid frame -> oframe_err=1, ocrc_err=0.
- irst pulsed after bit 20 of a frame, then a good frame sent after a new istart -> no odone from the first frame, the second frame decodes cleanly.
- With SD_R2_RESP_EN and ilong=1: a 136-bit frame with a correct CRC7 over a 120-bit payload 0x1D41_4453_4430_3030_0... -> olong equals the payload, ocrc_err=0, odone after bit 136.
